// File: rtl/pizza_pkg.sv
// Shared definitions for the pizza-delivery display path.
// Holds the screen geometry, field widths, colour constants, the shadow-buffer FSM
// state encoding and the pixel address helper.
package pizza_pkg;

    localparam int unsigned H_RES    = 160;
    localparam int unsigned V_RES    = 120;
    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;
    localparam int unsigned COLOUR_W = 7;
    localparam int unsigned NUM_PIX  = H_RES * V_RES;
    localparam int unsigned ADDR_W   = 15;

    localparam logic [COLOUR_W-1:0] COL_BLACK  = 7'd0;
    localparam logic [COLOUR_W-1:0] COL_YELLOW = 7'd60;

    typedef enum logic [1:0] {
        StClear  = 2'd0,
        StIdle   = 2'd1,
        StRdWait = 2'd2,
        StRdOut  = 2'd3
    } shadow_state_e;

    // Row-major linear address. Only meaningful for in-range coordinates.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [X_W-1:0] x,
                                                  input logic [Y_W-1:0] y);
        return ADDR_W'(ADDR_W'(y) * ADDR_W'(H_RES)) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/plot_shadow_buffer_if.sv
// Bundle of the plot-bus tap, the clear request and the pixel query port of the
// shadow buffer.
// master: the side that plots, clears and issues reads (game logic / draw blocks).
// slave : plot_shadow_buffer.
// Signals: plot/x/y/colour (write tap), clear, rd_req/rd_x/rd_y (query),
//          rd_ready/rd_valid/rd_colour/rd_oob (query response), busy, drop_count.
interface plot_shadow_buffer_if;
    import pizza_pkg::*;

    logic                plot;
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
    logic                clear;
    logic                rd_req;
    logic [X_W-1:0]      rd_x;
    logic [Y_W-1:0]      rd_y;
    logic                rd_ready;
    logic                rd_valid;
    logic [COLOUR_W-1:0] rd_colour;
    logic                rd_oob;
    logic                busy;
    logic [7:0]          drop_count;

    modport master (
        output plot, x, y, colour, clear, rd_req, rd_x, rd_y,
        input  rd_ready, rd_valid, rd_colour, rd_oob, busy, drop_count
    );

    modport slave (
        input  plot, x, y, colour, clear, rd_req, rd_x, rd_y,
        output rd_ready, rd_valid, rd_colour, rd_oob, busy, drop_count
    );

endinterface

// File: rtl/shadow_ram.sv
// Simple dual-port RAM holding the screen shadow copy.
// Ports: clk, we/waddr/wdata (write port), re/raddr/rdata (synchronous read port).
// Read during write to the same address returns the old data; the caller forwards.
module shadow_ram #(
    parameter int unsigned DEPTH  = 19200,
    parameter int unsigned WIDTH  = 7,
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/plot_shadow_buffer.sv
// Shadow copy of the 160x120 screen, fed by tapping the plot bus, with a
// req/ready/valid pixel query port for game logic.
// Ports: clk, resetn (synchronous, active low), bus (plot_shadow_buffer_if.slave).
// After reset, or on clear in IDLE, the whole screen is swept to CLEAR_COLOUR
// (busy high); plots during the sweep or outside the screen are counted as dropped.
module plot_shadow_buffer
    import pizza_pkg::*;
#(
    parameter logic [COLOUR_W-1:0] CLEAR_COLOUR = COL_BLACK
) (
    input  logic                 clk,
    input  logic                 resetn,
    plot_shadow_buffer_if.slave  bus
);

    shadow_state_e       state_q;
    logic [ADDR_W-1:0]   sweep_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic                req_oob_q;
    logic                fwd_q;
    logic [COLOUR_W-1:0] fwd_colour_q;
    logic                rd_valid_q;
    logic [COLOUR_W-1:0] rd_colour_q;
    logic                rd_oob_q;
    logic                rd_ready_q;
    logic                busy_q;
    logic [7:0]          drop_q;

    logic                wr_in_range;
    logic                rd_in_range;
    logic [ADDR_W-1:0]   wr_addr;
    logic                plot_ok;
    logic                plot_drop;
    logic                ram_we;
    logic [ADDR_W-1:0]   ram_waddr;
    logic [COLOUR_W-1:0] ram_wdata;
    logic                ram_re;
    logic [COLOUR_W-1:0] ram_rdata;
    logic                fwd_hit;

    always_comb begin
        wr_in_range = (bus.x < X_W'(H_RES)) && (bus.y < Y_W'(V_RES));
        rd_in_range = (bus.rd_x < X_W'(H_RES)) && (bus.rd_y < Y_W'(V_RES));
        wr_addr     = pix_addr(bus.x, bus.y);
        plot_ok     = bus.plot && wr_in_range && (state_q != StClear);
        plot_drop   = bus.plot && !plot_ok;
        // The sweep owns the write port; plots are dropped rather than stalled.
        ram_we      = (state_q == StClear) || plot_ok;
        ram_waddr   = (state_q == StClear) ? sweep_q : wr_addr;
        ram_wdata   = (state_q == StClear) ? CLEAR_COLOUR : bus.colour;
        ram_re      = (state_q == StRdWait) && !req_oob_q;
        // RAM returns old data on a same-address collision, so the write wins here.
        fwd_hit     = (state_q == StRdWait) && !req_oob_q && plot_ok && (wr_addr == rd_addr_q);
    end

    shadow_ram #(
        .DEPTH  (NUM_PIX),
        .WIDTH  (COLOUR_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (rd_addr_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= StClear;
            sweep_q      <= '0;
            rd_addr_q    <= '0;
            req_oob_q    <= 1'b0;
            fwd_q        <= 1'b0;
            fwd_colour_q <= '0;
            rd_valid_q   <= 1'b0;
            rd_colour_q  <= '0;
            rd_oob_q     <= 1'b0;
            rd_ready_q   <= 1'b0;
            busy_q       <= 1'b1;
            drop_q       <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            if (plot_drop && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
            unique case (state_q)
                StClear: begin
                    sweep_q <= sweep_q + ADDR_W'(1);
                    if (sweep_q == ADDR_W'(NUM_PIX - 1)) begin
                        state_q    <= StIdle;
                        busy_q     <= 1'b0;
                        rd_ready_q <= 1'b1;
                    end
                end
                StIdle: begin
                    if (bus.clear) begin
                        state_q    <= StClear;
                        sweep_q    <= '0;
                        busy_q     <= 1'b1;
                        rd_ready_q <= 1'b0;
                    end else if (bus.rd_req) begin
                        state_q    <= StRdWait;
                        rd_addr_q  <= pix_addr(bus.rd_x, bus.rd_y);
                        req_oob_q  <= !rd_in_range;
                        rd_ready_q <= 1'b0;
                    end
                end
                StRdWait: begin
                    fwd_q        <= fwd_hit;
                    fwd_colour_q <= bus.colour;
                    state_q      <= StRdOut;
                end
                StRdOut: begin
                    rd_valid_q  <= 1'b1;
                    rd_oob_q    <= req_oob_q;
                    rd_colour_q <= req_oob_q ? '0 : (fwd_q ? fwd_colour_q : ram_rdata);
                    state_q     <= StIdle;
                    rd_ready_q  <= 1'b1;
                end
                default: state_q <= StClear;
            endcase
        end
    end

    assign bus.rd_ready   = rd_ready_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_colour  = rd_colour_q;
    assign bus.rd_oob     = rd_oob_q;
    assign bus.busy       = busy_q;
    assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_plot_shadow_buffer.sv
// Scoreboard bench for plot_shadow_buffer: reads push their expected response,
// a negedge monitor pops and compares whenever rd_valid is seen.
module tb_plot_shadow_buffer;
    import pizza_pkg::*;

    typedef struct packed {
        logic [COLOUR_W-1:0] colour;
        logic                oob;
    } exp_t;

    logic clk;
    logic resetn;
    int   n_vec;
    int   n_err;
    exp_t exp_q[$];

    plot_shadow_buffer_if bus();

    plot_shadow_buffer dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: every rd_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.rd_valid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_rd_valid: got colour %0d oob %0d, expected no response",
                         bus.rd_colour, bus.rd_oob);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.rd_colour != e.colour || bus.rd_oob != e.oob) begin
                    n_err++;
                    $display("FAIL rd_data: got colour %0d oob %0d, expected colour %0d oob %0d",
                             bus.rd_colour, bus.rd_oob, e.colour, e.oob);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bus.rd_ready && n < 50) begin
            step();
            n++;
        end
        if (!bus.rd_ready) check("rd_ready_timeout", 0, 1);
    endtask

    task automatic wait_sweep(output int cycles);
        cycles = 0;
        while (bus.busy && cycles < 25000) begin
            step();
            cycles++;
        end
    endtask

    task automatic plot_px(input int x, input int y, input int c);
        bus.plot   = 1'b1;
        bus.x      = X_W'(x);
        bus.y      = Y_W'(y);
        bus.colour = COLOUR_W'(c);
        step();
        bus.plot   = 1'b0;
    endtask

    // Optionally plots (fx,fy,fcol) in the RD_WAIT cycle of this read.
    task automatic do_read(input int x, input int y, input int exp_c, input bit exp_oob,
                           input bit fwd, input int fx, input int fy, input int fcol);
        exp_t e;
        wait_ready();
        bus.rd_req = 1'b1;
        bus.rd_x   = X_W'(x);
        bus.rd_y   = Y_W'(y);
        e.colour   = COLOUR_W'(exp_c);
        e.oob      = exp_oob;
        exp_q.push_back(e);
        step();
        bus.rd_req = 1'b0;
        if (fwd) begin
            bus.plot   = 1'b1;
            bus.x      = X_W'(fx);
            bus.y      = Y_W'(fy);
            bus.colour = COLOUR_W'(fcol);
        end
        step();
        bus.plot = 1'b0;
        check("rd_latency_n1", int'(bus.rd_valid), 0);
        step();
        check("rd_latency_n2", int'(bus.rd_valid), 1);
    endtask

    task automatic rd(input int x, input int y, input int exp_c, input bit exp_oob);
        do_read(x, y, exp_c, exp_oob, 1'b0, 0, 0, 0);
    endtask

    initial begin
        int cyc;
        n_vec      = 0;
        n_err      = 0;
        resetn     = 1'b0;
        bus.plot   = 1'b0;
        bus.x      = '0;
        bus.y      = '0;
        bus.colour = '0;
        bus.clear  = 1'b0;
        bus.rd_req = 1'b0;
        bus.rd_x   = '0;
        bus.rd_y   = '0;

        // 1. reset values and sweep length
        repeat (3) step();
        check("rst_busy", int'(bus.busy), 1);
        check("rst_rd_ready", int'(bus.rd_ready), 0);
        check("rst_rd_valid", int'(bus.rd_valid), 0);
        check("rst_rd_colour", int'(bus.rd_colour), 0);
        check("rst_rd_oob", int'(bus.rd_oob), 0);
        check("rst_drop_count", int'(bus.drop_count), 0);
        resetn = 1'b1;
        wait_sweep(cyc);
        check("sweep_cycles", cyc, 19200);
        check("ready_after_sweep", int'(bus.rd_ready), 1);
        rd(5, 21, 0, 1'b0);

        // 2. plot then read back
        plot_px(0, 21, 60);
        rd(0, 21, 60, 1'b0);
        rd(1, 21, 0, 1'b0);

        // 3. out-of-range reads and dropped plot
        rd(160, 0, 0, 1'b1);
        rd(0, 120, 0, 1'b1);
        check("drop_before", int'(bus.drop_count), 0);
        plot_px(200, 5, 60);
        check("drop_after_oob_plot", int'(bus.drop_count), 1);
        rd(40, 6, 0, 1'b0);   // 5*160+200 would alias (40,6)

        // 4. forwarding in RD_WAIT, and a non-matching write that must not forward
        do_read(10, 10, 60, 1'b0, 1'b1, 10, 10, 60);
        rd(10, 10, 60, 1'b0);
        do_read(11, 10, 0, 1'b0, 1'b1, 12, 10, 5);
        rd(12, 10, 5, 1'b0);

        // 5. paint, clear, plot during sweep
        for (int i = 0; i < 16; i++) plot_px(i * 9, i * 7, 60);
        rd(45, 35, 60, 1'b0);
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        check("clear_busy", int'(bus.busy), 1);
        check("clear_rd_ready", int'(bus.rd_ready), 0);
        plot_px(3, 3, 1);
        plot_px(4, 3, 1);
        check("drop_during_sweep", int'(bus.drop_count), 3);
        wait_sweep(cyc);
        check("clear_sweep_done", int'(bus.busy), 0);
        for (int i = 0; i < 16; i++) rd(i * 9, i * 7, 0, 1'b0);
        rd(3, 3, 0, 1'b0);
        rd(0, 21, 0, 1'b0);

        // 6. reset during RD_WAIT aborts the read
        plot_px(7, 7, 60);
        wait_ready();
        bus.rd_req = 1'b1;
        bus.rd_x   = X_W'(7);
        bus.rd_y   = Y_W'(7);
        step();
        bus.rd_req = 1'b0;
        resetn     = 1'b0;
        step();
        resetn     = 1'b1;
        check("rst_rdwait_busy", int'(bus.busy), 1);
        check("rst_rdwait_valid", int'(bus.rd_valid), 0);
        check("rst_rdwait_ready", int'(bus.rd_ready), 0);
        check("rst_rdwait_drop", int'(bus.drop_count), 0);
        wait_sweep(cyc);
        check("resweep_cycles", cyc, 19200);
        rd(7, 7, 0, 1'b0);
        repeat (4) step();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
